// File: rtl/mmio_peripheral_bus.sv
// Memory-mapped peripheral window on the CPU data bus: timer with interrupt,
// LED register, synchronised switches, hex display scanner and cycle counter.
// Loads and stores are single-cycle; rdata and hit are combinational from addr.
module mmio_peripheral_bus #(
  parameter logic [31:0] BASE_ADDR  = 32'h4000_0000,
  parameter int          LED_W      = 8,
  parameter int          SW_W       = 8,
  parameter int          NUM_DIGITS = 4,
  parameter int          SCAN_DIV   = 50000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           addr,
  input  logic [31:0]           wdata,
  input  logic                  mem_read,
  input  logic                  mem_write,
  output logic [31:0]           rdata,
  output logic                  hit,
  output logic                  irq,
  output logic [LED_W-1:0]      led,
  input  logic [SW_W-1:0]       sw,
  output logic [NUM_DIGITS-1:0] an_n,
  output logic [6:0]            seg_n
);

  localparam int DIGI_W = 4 * NUM_DIGITS;
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W  = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_ONE   = NUM_DIGITS'(1);

  logic [31:0]           th_q, tl_q, systick_q;
  logic                  en_q, ie_q, if_q;
  logic [LED_W-1:0]      led_q;
  logic [DIGI_W-1:0]     digi_q, digi_nxt;
  logic [SW_W-1:0]       sw_meta, sw_sync;
  logic [CNT_W-1:0]      scan_cnt, scan_cnt_nxt;
  logic [IDX_W-1:0]      digit_idx, idx_nxt;
  logic [3:0]            nib_nxt;
  logic [NUM_DIGITS-1:0] an_q;
  logic [6:0]            seg_q;
  logic [4:0]            off;
  logic                  wr, wr_th, wr_tl, wr_tcon, wr_led, wr_digi, ovf;

  function automatic logic [6:0] hex_seg(input logic [3:0] v);
    hex_seg = 7'b1000000;
    case (v)
      4'h0: hex_seg = 7'b1000000;
      4'h1: hex_seg = 7'b1111001;
      4'h2: hex_seg = 7'b0100100;
      4'h3: hex_seg = 7'b0110000;
      4'h4: hex_seg = 7'b0011001;
      4'h5: hex_seg = 7'b0010010;
      4'h6: hex_seg = 7'b0000010;
      4'h7: hex_seg = 7'b1111000;
      4'h8: hex_seg = 7'b0000000;
      4'h9: hex_seg = 7'b0010000;
      4'hA: hex_seg = 7'b0001000;
      4'hB: hex_seg = 7'b0000011;
      4'hC: hex_seg = 7'b1000110;
      4'hD: hex_seg = 7'b0100001;
      4'hE: hex_seg = 7'b0000110;
      4'hF: hex_seg = 7'b0001110;
      default: hex_seg = 7'b1000000;
    endcase
  endfunction

  assign off     = addr[4:0];
  assign hit     = (addr[31:5] == BASE_ADDR[31:5]) && (addr[1:0] == 2'b00) && (off <= 5'h18);
  assign wr      = hit && mem_write;
  assign wr_th   = wr && (off == 5'h00);
  assign wr_tl   = wr && (off == 5'h04);
  assign wr_tcon = wr && (off == 5'h08);
  assign wr_led  = wr && (off == 5'h0C);
  assign wr_digi = wr && (off == 5'h14);
  assign ovf     = en_q && (tl_q == 32'hFFFF_FFFF);

  assign led   = led_q;
  assign an_n  = an_q;
  assign seg_n = seg_q;

  // Read mux: zero unless a load hits the window; narrow registers zero-extend.
  always_comb begin
    rdata = '0;
    if (hit && mem_read) begin
      case (off)
        5'h00: rdata = th_q;
        5'h04: rdata = tl_q;
        5'h08: rdata[2:0] = {if_q, ie_q, en_q};
        5'h0C: rdata[LED_W-1:0] = led_q;
        5'h10: rdata[SW_W-1:0] = sw_sync;
        5'h14: rdata[DIGI_W-1:0] = digi_q;
        5'h18: rdata = systick_q;
        default: rdata = '0;
      endcase
    end
  end

  // Timer: CPU write to TL beats increment/reload; overflow setting IF beats a W1C.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      th_q <= '0;
      tl_q <= '0;
      en_q <= 1'b0;
      ie_q <= 1'b0;
      if_q <= 1'b0;
      irq  <= 1'b0;
    end else begin
      if (wr_th) th_q <= wdata;
      if (wr_tl) tl_q <= wdata;
      else if (ovf) tl_q <= th_q;
      else if (en_q) tl_q <= tl_q + 32'd1;
      if (wr_tcon) begin
        en_q <= wdata[0];
        ie_q <= wdata[1];
      end
      if (ovf && ie_q) if_q <= 1'b1;
      else if (wr_tcon && wdata[2]) if_q <= 1'b0;
      irq <= ie_q && if_q;
    end
  end

  // Plain registers, cycle counter and switch synchroniser.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_q     <= '0;
      digi_q    <= '0;
      systick_q <= '0;
      sw_meta   <= '0;
      sw_sync   <= '0;
    end else begin
      if (wr_led)  led_q  <= wdata[LED_W-1:0];
      if (wr_digi) digi_q <= wdata[DIGI_W-1:0];
      systick_q <= systick_q + 32'd1;
      sw_meta   <= sw;
      sw_sync   <= sw_meta;
    end
  end

  // Next scan position and the nibble it will show, including a same-cycle DIGI write.
  always_comb begin
    scan_cnt_nxt = scan_cnt + CNT_W'(1);
    idx_nxt      = digit_idx;
    if (scan_cnt == CNT_LAST) begin
      scan_cnt_nxt = '0;
      idx_nxt      = (digit_idx == IDX_LAST) ? '0 : digit_idx + IDX_W'(1);
    end
    digi_nxt = wr_digi ? wdata[DIGI_W-1:0] : digi_q;
    nib_nxt  = digi_nxt[{idx_nxt, 2'b00} +: 4];
  end

  // Scanner: an_n and seg_n are registered together so they switch on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_cnt  <= '0;
      digit_idx <= '0;
      an_q      <= ~AN_ONE;
      seg_q     <= 7'b1000000;
    end else begin
      scan_cnt  <= scan_cnt_nxt;
      digit_idx <= idx_nxt;
      an_q      <= ~(AN_ONE << idx_nxt);
      seg_q     <= hex_seg(nib_nxt);
    end
  end

endmodule

// File: tb/tb_mmio_peripheral_bus.sv
// Bench for mmio_peripheral_bus: reference model of the register map plus directed
// vectors with literal expectations for timer, decode, switch and scanner behaviour.
module tb_mmio_peripheral_bus;

  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam int SCAN_DIV = 4;
  localparam logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic        mem_read = 1'b0, mem_write = 1'b0;
  logic [7:0]  sw = '0;
  logic [31:0] rdata;
  logic        hit, irq;
  logic [7:0]  led;
  logic [3:0]  an_n;
  logic [6:0]  seg_n;

  int n_vec = 0;
  int n_err = 0;

  mmio_peripheral_bus #(
    .BASE_ADDR(BASE), .LED_W(8), .SW_W(8), .NUM_DIGITS(4), .SCAN_DIV(SCAN_DIV)
  ) dut (
    .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .mem_read(mem_read),
    .mem_write(mem_write), .rdata(rdata), .hit(hit), .irq(irq), .led(led), .sw(sw),
    .an_n(an_n), .seg_n(seg_n)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_th, m_tl;
  logic        m_en, m_ie, m_if, m_irq;
  logic [7:0]  m_led, m_sw1, m_sw2;
  logic [15:0] m_digi;
  longint      m_cyc;
  logic        wr_ok, ov;
  logic [31:0] woff;

  function automatic bit in_win(input logic [31:0] a);
    return (a >= BASE) && ((a - BASE) <= 32'h18) && (a % 4 == 0);
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a, input logic rd);
    if (!(rd && in_win(a))) return 32'h0;
    case (a - BASE)
      32'h00: return m_th;
      32'h04: return m_tl;
      32'h08: return {29'h0, m_if, m_ie, m_en};
      32'h0C: return {24'h0, m_led};
      32'h10: return {24'h0, m_sw2};
      32'h14: return {16'h0, m_digi};
      32'h18: return 32'(m_cyc);
      default: return 32'h0;
    endcase
  endfunction

  function automatic int m_idx();
    return int'((m_cyc / SCAN_DIV) % 4);
  endfunction

  // Model state advances on each clock from the inputs the bench drives.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_th <= '0; m_tl <= '0; m_en <= 0; m_ie <= 0; m_if <= 0; m_irq <= 0;
      m_led <= '0; m_digi <= '0; m_sw1 <= '0; m_sw2 <= '0; m_cyc <= 0;
    end else begin
      wr_ok = mem_write && in_win(addr);
      woff  = addr - BASE;
      ov    = m_en && (m_tl == 32'hFFFF_FFFF);
      if (wr_ok && woff == 32'h00) m_th <= wdata;
      if (wr_ok && woff == 32'h04) m_tl <= wdata;
      else if (ov) m_tl <= m_th;
      else if (m_en) m_tl <= m_tl + 32'd1;
      if (wr_ok && woff == 32'h08) begin
        m_en <= wdata[0];
        m_ie <= wdata[1];
      end
      if (ov && m_ie) m_if <= 1'b1;
      else if (wr_ok && woff == 32'h08 && wdata[2]) m_if <= 1'b0;
      m_irq <= m_ie && m_if;
      if (wr_ok && woff == 32'h0C) m_led <= wdata[7:0];
      if (wr_ok && woff == 32'h14) m_digi <= wdata[15:0];
      m_sw2 <= m_sw1;
      m_sw1 <= sw;
      m_cyc <= m_cyc + 1;
    end
  end

  // Every-cycle comparison against the model, mid-cycle.
  always @(negedge clk) begin
    chk("hit", {31'h0, hit}, {31'h0, in_win(addr)});
    chk("rdata", rdata, m_read(addr, mem_read));
    chk("irq", {31'h0, irq}, {31'h0, m_irq});
    chk("led", {24'h0, led}, {24'h0, m_led});
    chk("an_n", {28'h0, an_n}, {28'h0, ~(4'b0001 << m_idx())});
    chk("seg_n", {25'h0, seg_n}, {25'h0, HEX[m_digi[m_idx()*4 +: 4]]});
  end

  // ---------------- directed stimulus ----------------
  task automatic wr_bus(input logic [31:0] a, input logic [31:0] d);
    addr = a; wdata = d; mem_write = 1'b1; mem_read = 1'b0;
    @(posedge clk); #1;
    mem_write = 1'b0;
  endtask

  task automatic rd_set(input logic [31:0] a);
    addr = a; mem_read = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  logic [31:0] exp_tl  [7] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'hFFFF_FFFD,
                               32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFC};
  logic        exp_irq [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  logic [7:0]  exp_sw  [3] = '{8'h00, 8'h00, 8'h3C};
  bit found;

  initial begin
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    chk("rst_led", {24'h0, led}, 32'h0);
    chk("rst_an", {28'h0, an_n}, 32'hE);
    chk("rst_seg", {25'h0, seg_n}, 32'h40);
    @(posedge clk); #1 reset = 1'b0;

    // decode
    addr = BASE + 32'h0C; wdata = 32'hA5; mem_write = 1'b1;
    #1 chk("hit_led", {31'h0, hit}, 32'h1);
    @(posedge clk); #1 mem_write = 1'b0;
    chk("led_a5", {24'h0, led}, 32'hA5);
    addr = BASE + 32'h0D; wdata = 32'h5A; mem_write = 1'b1;
    #1 chk("hit_misaligned", {31'h0, hit}, 32'h0);
    @(posedge clk); #1 mem_write = 1'b0;
    chk("led_kept", {24'h0, led}, 32'hA5);
    addr = BASE + 32'h1C;
    #1 chk("hit_1c", {31'h0, hit}, 32'h0);
    wr_bus(BASE + 32'h10, 32'hFF);
    rd_set(BASE + 32'h10);
    #1 chk("sw_ro", rdata, 32'h0);

    // switch synchroniser latency
    sw = 8'h3C;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("sw_sync", rdata, {24'h0, exp_sw[i]});
    end
    @(posedge clk); #1;

    // timer reload and interrupt
    wr_bus(BASE + 32'h00, 32'hFFFF_FFFC);
    wr_bus(BASE + 32'h04, 32'hFFFF_FFFE);
    wr_bus(BASE + 32'h08, 32'h3);
    rd_set(BASE + 32'h04);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk("tl_seq", rdata, exp_tl[i]);
      chk("irq_seq", {31'h0, irq}, {31'h0, exp_irq[i]});
      @(posedge clk); #1;
    end

    // W1C in the overflow cycle loses to the set
    found = 0;
    for (int i = 0; i < 8 && !found; i++) begin
      @(negedge clk);
      if (rdata == 32'hFFFF_FFFF) found = 1;
    end
    chk("ovf_found", {31'h0, found}, 32'h1);
    #1 wr_bus(BASE + 32'h08, 32'h7);
    rd_set(BASE + 32'h08);
    @(negedge clk);
    chk("if_set_wins", rdata, 32'h7);
    chk("irq_held", {31'h0, irq}, 32'h1);
    #1 wr_bus(BASE + 32'h08, 32'h7);
    rd_set(BASE + 32'h08);
    @(negedge clk);
    chk("if_cleared", rdata, 32'h3);
    chk("irq_lag", {31'h0, irq}, 32'h1);
    @(negedge clk);
    chk("irq_drop", {31'h0, irq}, 32'h0);
    #1 rd_set(BASE + 32'h18);
    repeat (2) @(posedge clk);
    #1;

    // reset mid-run
    reset = 1'b1;
    rd_set(BASE + 32'h04);
    #1 chk("mrst_tl", rdata, 32'h0);
    rd_set(BASE + 32'h08);
    #1 chk("mrst_tcon", rdata, 32'h0);
    rd_set(BASE + 32'h18);
    #1 chk("mrst_systick", rdata, 32'h0);
    chk("mrst_irq", {31'h0, irq}, 32'h0);
    chk("mrst_led", {24'h0, led}, 32'h0);
    chk("mrst_an", {28'h0, an_n}, 32'hE);
    chk("mrst_seg", {25'h0, seg_n}, 32'h40);
    @(posedge clk); #1 reset = 1'b0;

    // scanner
    wr_bus(BASE + 32'h14, 32'h4321);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      case (k)
        1, 3:   begin chk("scan_an", {28'h0, an_n}, 32'hE); chk("scan_seg", {25'h0, seg_n}, 32'h79); end
        4:      begin chk("scan_an", {28'h0, an_n}, 32'hD); chk("scan_seg", {25'h0, seg_n}, 32'h24); end
        8, 11:  begin chk("scan_an", {28'h0, an_n}, 32'hB); chk("scan_seg", {25'h0, seg_n}, 32'h30); end
        12, 15: begin chk("scan_an", {28'h0, an_n}, 32'h7); chk("scan_seg", {25'h0, seg_n}, 32'h19); end
        16:     begin chk("scan_wrap_an", {28'h0, an_n}, 32'hE); chk("scan_wrap_seg", {25'h0, seg_n}, 32'h79); end
        default: ;
      endcase
      @(posedge clk); #1;
    end
    wr_bus(BASE + 32'h14, 32'h432F);
    @(negedge clk);
    chk("digi_live_an", {28'h0, an_n}, 32'hE);
    chk("digi_live_seg", {25'h0, seg_n}, 32'h0E);
    @(posedge clk); #1;

    // ignored writes and a full read sweep
    wr_bus(BASE + 32'h00, 32'h1234_5678);
    wr_bus(BASE + 32'h04, 32'h0000_00AA);
    wr_bus(BASE + 32'h0C, 32'hFFFF_FF3C);
    wr_bus(BASE + 32'h18, 32'h0);
    wr_bus(BASE + 32'h10, 32'hFF);
    wr_bus(BASE + 32'h2C, 32'h11);
    wr_bus(32'h5000_000C, 32'h22);
    wr_bus(BASE + 32'h0E, 32'h33);
    for (int o = 0; o < 32; o++) begin
      rd_set(BASE + 32'(o));
      @(negedge clk);
      @(posedge clk); #1;
    end
    rd_set(32'h3FFF_FFFC);
    @(negedge clk);
    mem_read = 1'b0;
    @(posedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
